// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Package : game_pkg
//  Purpose : Shared types and constants for the round logic: magazine loader
//            state encoding, bitmap width, LFSR feedback taps, LFSR step
//            helper and the item code table used by the item logic.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package game_pkg;

  // Magazine loader states, in the order a round walks through them.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GEN_TOTAL = 3'd1,
    ST_GEN_LIVE  = 3'd2,
    ST_FILL      = 3'd3,
    ST_SHUFFLE   = 3'd4,
    ST_READY     = 3'd5,
    ST_EMPTY     = 3'd6
  } loader_state_t;

  localparam int BITMAP_W = 8;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Item codes shared with the item logic.
  localparam logic [2:0] ITEM_NONE      = 3'd0;
  localparam logic [2:0] ITEM_MAGNIFIER = 3'd1;
  localparam logic [2:0] ITEM_CIGARETTE = 3'd2;
  localparam logic [2:0] ITEM_BEER      = 3'd3;
  localparam logic [2:0] ITEM_HANDCUFF  = 3'd4;
  localparam logic [2:0] ITEM_SAW       = 3'd5;
  localparam logic [2:0] ITEM_PHONE     = 3'd6;
  localparam logic [2:0] ITEM_GUN       = 3'd7;

  // One LFSR step: shift towards the MSB, feedback enters at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/bullet_loader_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module  : lfsr16
//  Purpose : 16-bit Fibonacci LFSR (taps 16,14,13,11) with step enable and
//            synchronous load. A zero load value falls back to SEED so the
//            register can never lock up in the all-zero state.
//  Ports   : i_clk        clock
//            i_rst_n      async active-low reset (LFSR <= SEED)
//            i_step       advance one step this cycle
//            i_load       load i_load_value (overrides i_step)
//            i_load_value value to load (0 selects SEED)
//            o_lfsr       current LFSR state
//  Rev     : 1.0  initial release
// ============================================================================
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_step,
  input  logic        i_load,
  input  logic [15:0] i_load_value,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= SEED;
    end else if (i_load) begin
      r_lfsr <= (i_load_value == 16'h0000) ? SEED : i_load_value;
    end else if (i_step) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule : lfsr16
`default_nettype wire

// File: rtl/bullet_loader.sv
`default_nettype none
// ============================================================================
//  Module  : bullet_loader
//  Purpose : Builds each round's magazine (random size, random live count,
//            Fisher-Yates shuffled bitmap) and tracks the chamber pointer
//            as shots fire or the beer item ejects shells.
//  Config  : BULLET_LOADER_SEED_LOAD_EN adds i_seed_valid / i_seed so the
//            LFSR can be reseeded for repeatable rounds.
//  Ports   : i_clk, i_rst_n            clock, async active-low reset
//            i_start                   pulse: load a new magazine
//            i_fire                    pulse: chambered shell consumed
//            i_ptr_load_valid/i_ptr_load  pointer override (clamped to total)
//            i_seed_valid/i_seed       LFSR reseed (config option only)
//            o_bullet_bitmap           bit k = shell k is live
//            o_bullet_bitmap_ptr       chambered shell index
//            o_total_bullet            magazine size
//            o_total_bullet_remaining  total - ptr (combinational)
//            o_live_count              live shells loaded
//            o_ready / o_empty / o_busy  status
//  Rev     : 1.0  initial release
// ============================================================================
module bullet_loader
  import game_pkg::*;
#(
  parameter int          MIN_BULLETS = 2,
  parameter int          MAX_BULLETS = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_fire,
  input  logic                i_ptr_load_valid,
  input  logic [3:0]          i_ptr_load,
`ifdef BULLET_LOADER_SEED_LOAD_EN
  input  logic                i_seed_valid,
  input  logic [15:0]         i_seed,
`endif
  output logic [BITMAP_W-1:0] o_bullet_bitmap,
  output logic [3:0]          o_bullet_bitmap_ptr,
  output logic [3:0]          o_total_bullet,
  output logic [3:0]          o_total_bullet_remaining,
  output logic [3:0]          o_live_count,
  output logic                o_ready,
  output logic                o_empty,
  output logic                o_busy
);

  localparam logic [3:0] MIN_TOTAL  = 4'(MIN_BULLETS);
  localparam logic [3:0] TOTAL_SPAN = 4'(MAX_BULLETS - MIN_BULLETS);

  loader_state_t       r_state, w_state_nxt;
  logic [BITMAP_W-1:0] r_bitmap, w_bitmap_nxt;
  logic [3:0]          r_ptr, w_ptr_nxt;
  logic [3:0]          r_total, w_total_nxt;
  logic [3:0]          r_live, w_live_nxt;
  logic [2:0]          r_idx, w_idx_nxt;   // Fisher-Yates cursor

  logic [15:0]         w_lfsr;
  logic                w_seed_load;
  logic [15:0]         w_seed_value;
  logic [2:0]          w_rnd_lo;
  logic [3:0]          w_live_cand;
  logic [BITMAP_W-1:0] w_fill_mask;
  logic                w_start_ok;
  logic                w_unused_lfsr;

`ifdef BULLET_LOADER_SEED_LOAD_EN
  assign w_seed_load  = i_seed_valid;
  assign w_seed_value = i_seed;
`else
  assign w_seed_load  = 1'b0;
  assign w_seed_value = 16'h0000;
`endif

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_step       (1'b1),
    .i_load       (w_seed_load),
    .i_load_value (w_seed_value),
    .o_lfsr       (w_lfsr)
  );

  // Only the low six bits are drawn from; the rest live in the feedback path.
  assign w_unused_lfsr = ^w_lfsr[15:6];

  assign w_rnd_lo    = w_lfsr[2:0];
  assign w_live_cand = {1'b0, w_lfsr[5:3]} + 4'd1;
  assign w_fill_mask = 8'((9'd1 << r_live) - 9'd1);

  assign w_start_ok = i_start && ((r_state == ST_IDLE) ||
                                  (r_state == ST_READY) ||
                                  (r_state == ST_EMPTY));

  always_comb begin
    w_state_nxt  = r_state;
    w_bitmap_nxt = r_bitmap;
    w_ptr_nxt    = r_ptr;
    w_total_nxt  = r_total;
    w_live_nxt   = r_live;
    w_idx_nxt    = r_idx;

    case (r_state)
      ST_GEN_TOTAL: begin
        if ({1'b0, w_rnd_lo} <= TOTAL_SPAN) begin
          w_total_nxt = MIN_TOTAL + {1'b0, w_rnd_lo};
          w_state_nxt = ST_GEN_LIVE;
        end
      end
      ST_GEN_LIVE: begin
        // total >= 2 here, so total-1 cannot wrap; candidate is always >= 1.
        if (w_live_cand <= (r_total - 4'd1)) begin
          w_live_nxt  = w_live_cand;
          w_state_nxt = ST_FILL;
        end
      end
      ST_FILL: begin
        w_bitmap_nxt = w_fill_mask;
        w_idx_nxt    = 3'(r_total - 4'd1);
        w_state_nxt  = ST_SHUFFLE;
      end
      ST_SHUFFLE: begin
        // Draws above the cursor are rejected rather than folded, keeping
        // every permutation equally likely.
        if (w_rnd_lo <= r_idx) begin
          w_bitmap_nxt[r_idx]    = r_bitmap[w_rnd_lo];
          w_bitmap_nxt[w_rnd_lo] = r_bitmap[r_idx];
          w_idx_nxt              = r_idx - 3'd1;
          if (r_idx == 3'd1) begin
            w_state_nxt = ST_READY;
          end
        end
      end
      ST_READY: begin
        // A pointer load from the beer item takes priority over a shot.
        if (i_ptr_load_valid) begin
          w_ptr_nxt = (i_ptr_load > r_total) ? r_total : i_ptr_load;
        end else if (i_fire) begin
          w_ptr_nxt = r_ptr + 4'd1;
        end
        if (w_ptr_nxt == r_total) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: begin
        // IDLE and EMPTY wait for a start request.
      end
    endcase

    if (w_start_ok) begin
      w_ptr_nxt    = 4'd0;
      w_bitmap_nxt = '0;
      w_total_nxt  = 4'd0;
      w_live_nxt   = 4'd0;
      w_idx_nxt    = 3'd0;
      w_state_nxt  = ST_GEN_TOTAL;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_bitmap <= '0;
      r_ptr    <= 4'd0;
      r_total  <= 4'd0;
      r_live   <= 4'd0;
      r_idx    <= 3'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitmap <= w_bitmap_nxt;
      r_ptr    <= w_ptr_nxt;
      r_total  <= w_total_nxt;
      r_live   <= w_live_nxt;
      r_idx    <= w_idx_nxt;
    end
  end

  assign o_bullet_bitmap          = r_bitmap;
  assign o_bullet_bitmap_ptr      = r_ptr;
  assign o_total_bullet           = r_total;
  assign o_total_bullet_remaining = r_total - r_ptr;
  assign o_live_count             = r_live;
  assign o_ready                  = (r_state == ST_READY);
  assign o_empty                  = (r_state == ST_EMPTY);
  assign o_busy                   = (r_state == ST_GEN_TOTAL) ||
                                    (r_state == ST_GEN_LIVE)  ||
                                    (r_state == ST_FILL)      ||
                                    (r_state == ST_SHUFFLE);

endmodule : bullet_loader
`default_nettype wire

// File: tb/tb_bullet_loader.sv
`default_nettype none
// ============================================================================
//  Module  : tb_bullet_loader
//  Purpose : Directed self-checking bench for bullet_loader. An independent
//            LFSR model predicts every magazine (size, live count, shuffled
//            bitmap and generation latency) from the LFSR value at start.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_bullet_loader;

  localparam int          MINB = 2;
  localparam int          MAXB = 8;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic        i_fire = 1'b0;
  logic        i_ptr_load_valid = 1'b0;
  logic [3:0]  i_ptr_load = 4'd0;
`ifdef BULLET_LOADER_SEED_LOAD_EN
  logic        i_seed_valid = 1'b0;
  logic [15:0] i_seed = 16'h0000;
`endif
  logic [7:0]  o_bullet_bitmap;
  logic [3:0]  o_bullet_bitmap_ptr;
  logic [3:0]  o_total_bullet;
  logic [3:0]  o_total_bullet_remaining;
  logic [3:0]  o_live_count;
  logic        o_ready;
  logic        o_empty;
  logic        o_busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_lfsr;
  logic [3:0]  exp_total;
  logic [3:0]  exp_live;
  logic [7:0]  exp_bitmap;
  logic [3:0]  a_total;
  logic [7:0]  a_bitmap;

  bullet_loader #(
    .MIN_BULLETS (MINB),
    .MAX_BULLETS (MAXB),
    .LFSR_SEED   (SEED)
  ) dut (
    .i_clk                    (i_clk),
    .i_rst_n                  (i_rst_n),
    .i_start                  (i_start),
    .i_fire                   (i_fire),
    .i_ptr_load_valid         (i_ptr_load_valid),
    .i_ptr_load               (i_ptr_load),
`ifdef BULLET_LOADER_SEED_LOAD_EN
    .i_seed_valid             (i_seed_valid),
    .i_seed                   (i_seed),
`endif
    .o_bullet_bitmap          (o_bullet_bitmap),
    .o_bullet_bitmap_ptr      (o_bullet_bitmap_ptr),
    .o_total_bullet           (o_total_bullet),
    .o_total_bullet_remaining (o_total_bullet_remaining),
    .o_live_count             (o_live_count),
    .o_ready                  (o_ready),
    .o_empty                  (o_empty),
    .o_busy                   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [15:0] mstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Reference LFSR, stepped on every edge like the design's.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) m_lfsr <= SEED;
`ifdef BULLET_LOADER_SEED_LOAD_EN
    else if (i_seed_valid) m_lfsr <= (i_seed == 16'h0) ? SEED : i_seed;
`endif
    else m_lfsr <= mstep(m_lfsr);
  end

  // Given the LFSR value at the accepting edge, play the generation out.
  // cyc = edges after the start edge until READY is entered.
  function automatic void predict(input logic [15:0] l0, output logic [3:0] tot,
                                  output logic [3:0] liv, output logic [7:0] bm,
                                  output int cyc);
    logic [15:0] l;
    int r, t, lv, i;
    logic b;
    l = mstep(l0);
    cyc = 0;
    do begin r = int'(l[2:0]); l = mstep(l); cyc++; end while (r > MAXB - MINB);
    t = MINB + r;
    do begin r = int'(l[5:3]) + 1; l = mstep(l); cyc++; end while (r > t - 1);
    lv = r;
    l = mstep(l); cyc++;
    bm = 8'((1 << lv) - 1);
    i = t - 1;
    while (i > 0) begin
      r = int'(l[2:0]); l = mstep(l); cyc++;
      if (r <= i) begin
        b = bm[i]; bm[i] = bm[r]; bm[r] = b;
        i--;
      end
    end
    tot = 4'(t);
    liv = 4'(lv);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    chk("rst_bitmap", o_bullet_bitmap, 0);
    chk("rst_ptr", o_bullet_bitmap_ptr, 0);
    chk("rst_total", o_total_bullet, 0);
    chk("rst_remaining", o_total_bullet_remaining, 0);
    chk("rst_live", o_live_count, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_empty", o_empty, 0);
    chk("rst_busy", o_busy, 0);
    repeat (3) tick();
    i_rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_busy", o_busy, 0);
    chk("idle_ready", o_ready, 0);
    chk("idle_total", o_total_bullet, 0);
  endtask

  // hold=1 keeps i_start asserted through the whole generation.
  task automatic start_round(input bit hold);
    int pcyc, cyc;
    logic [7:0] hi_mask;
    predict(m_lfsr, exp_total, exp_live, exp_bitmap, pcyc);
    i_start = 1'b1;
    tick();
    if (!hold) i_start = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_ptr_clr", o_bullet_bitmap_ptr, 0);
    chk("start_total_clr", o_total_bullet, 0);
    cyc = 0;
    while (!o_ready && cyc < 400) begin
      tick();
      cyc++;
    end
    i_start = 1'b0;
    chk("gen_latency", 16'(cyc), 16'(pcyc));
    chk("gen_total", o_total_bullet, exp_total);
    chk("gen_live", o_live_count, exp_live);
    chk("gen_bitmap", o_bullet_bitmap, exp_bitmap);
    hi_mask = 8'hFF << exp_total;
    chk("gen_bitmap_high_zero", o_bullet_bitmap & hi_mask, 0);
    chk("gen_popcount", 16'($countones(exp_bitmap)), exp_live);
    chk("gen_remaining", o_total_bullet_remaining, exp_total);
    chk("gen_busy_low", o_busy, 0);
    chk("gen_empty_low", o_empty, 0);
  endtask

  task automatic launch();
`ifdef BULLET_LOADER_SEED_LOAD_EN
    i_seed_valid = 1'b1;
    i_seed = 16'h1234;
    tick();
    i_seed_valid = 1'b0;
`else
    tick();
`endif
    start_round(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset state and quiet idle
    do_reset();

    // Seeded round A
    launch();
    chk("rangeA_total", 16'((exp_total >= 2) && (exp_total <= 8)), 1);
    chk("rangeA_live", 16'((exp_live >= 1) && (exp_live < exp_total)), 1);
    a_total = exp_total;
    a_bitmap = exp_bitmap;

    // Restart from READY, then abort it with reset mid-generation
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    chk("mid_busy", o_busy, 1);
    do_reset();

    // Same seed and timing must reproduce round A
    launch();
    chk("repeat_total", o_total_bullet, a_total);
    chk("repeat_bitmap", o_bullet_bitmap, a_bitmap);

    // Fire through the whole magazine
    t = int'(exp_total);
    for (int k = 1; k <= t; k++) begin
      i_fire = 1'b1;
      tick();
      i_fire = 1'b0;
      chk("fire_ptr", o_bullet_bitmap_ptr, 4'(k));
      chk("fire_remaining", o_total_bullet_remaining, 4'(t - k));
      chk("fire_empty", o_empty, 16'(k == t));
    end
    i_fire = 1'b1;
    tick();
    i_fire = 1'b0;
    chk("extra_fire_ptr", o_bullet_bitmap_ptr, 4'(t));
    chk("extra_fire_ready", o_ready, 0);
    i_ptr_load_valid = 1'b1;
    i_ptr_load = 4'd0;
    tick();
    i_ptr_load_valid = 1'b0;
    chk("empty_load_ignored", o_bullet_bitmap_ptr, 4'(t));
    chk("empty_stays", o_empty, 1);

    // Start from EMPTY: fresh round with ptr back at 0
    start_round(1'b0);
    chk("empty_restart_ptr", o_bullet_bitmap_ptr, 0);

    // Simultaneous fire and load: load wins
    i_fire = 1'b1;
    i_ptr_load_valid = 1'b1;
    i_ptr_load = 4'd2;
    tick();
    i_fire = 1'b0;
    i_ptr_load_valid = 1'b0;
    chk("fire_load_ptr", o_bullet_bitmap_ptr, 2);
    chk("fire_load_remaining", o_total_bullet_remaining, exp_total - 4'd2);
    chk("fire_load_empty", o_empty, 16'(exp_total == 4'd2));

    // Look for a 4-shell magazine, then overload the pointer
    for (int n = 0; n < 40; n++) begin
      start_round(1'b0);
      if (exp_total == 4'd4) break;
    end
    i_fire = 1'b1;
    tick();
    i_fire = 1'b0;
    chk("clamp_pre_ptr", o_bullet_bitmap_ptr, 1);
    i_ptr_load_valid = 1'b1;
    i_ptr_load = 4'd9;
    tick();
    i_ptr_load_valid = 1'b0;
    chk("clamp_ptr", o_bullet_bitmap_ptr, exp_total);
    chk("clamp_remaining", o_total_bullet_remaining, 0);
    chk("clamp_empty", o_empty, 1);
    chk("clamp_ready", o_ready, 0);

    // Start held high through generation (incl. SHUFFLE) is ignored
    start_round(1'b1);
    chk("busy_start_ptr", o_bullet_bitmap_ptr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bullet_loader
`default_nettype wire
